gradient_window: RTL and testbench

Streaming HOG gradient stage directly downstream of the line buffer. Each beat it accepts one vertical column of three pixels (one tap per line-buffer row) and the line buffer's border flag. It keeps a 3x3 sliding window and computes the centred-difference gradients gx and gy of the window centre, plus an L1 magnitude. Results go to the orientation-binning stage through a two-stage valid/ready pipeline.

---
 rtl/gradient_window.sv | 65 ++++++
 tb/tb_gradient_window.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gradient_window.sv
// gradient_window: 3x3 sliding-window centred-difference gradients with L1 magnitude
module gradient_window #(
   parameter  int DATA_WIDTH = 8,
   localparam int GRAD_WIDTH = DATA_WIDTH + 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [3*DATA_WIDTH-1:0]      in_col,
   input  logic                         in_valid,
   input  logic                         in_border,
   output logic                         in_ready,
   output logic signed [GRAD_WIDTH-1:0] out_gx,
   output logic signed [GRAD_WIDTH-1:0] out_gy,
   output logic [DATA_WIDTH:0]          out_mag,
   output logic                         out_valid,
   input  logic                         out_ready
);
   localparam int W = DATA_WIDTH;
   // Only the window taps the gradients read are stored: the newest column in full
   // and the centre-row pixel of the column before it.
   logic [3*W-1:0] c2;
   logic [W-1:0] c1_mid;
   logic [1:0] fill;
   logic signed [GRAD_WIDTH-1:0] gx, gy, s1_gx, s1_gy;
   logic [GRAD_WIDTH-1:0] ax, ay;
   logic s1_valid, s1_en, s2_en, acc;
   assign s2_en = !out_valid || out_ready;
   assign s1_en = !s1_valid || s2_en;
   assign in_ready = s1_en;
   assign acc = in_valid && in_ready;
   assign gx = $signed({1'b0, in_col[2*W-1:W]}) - $signed({1'b0, c1_mid});
   assign gy = $signed({1'b0, c2[3*W-1:2*W]}) - $signed({1'b0, c2[W-1:0]});
   assign ax = s1_gx[GRAD_WIDTH-1] ? $unsigned(-s1_gx) : $unsigned(s1_gx);
   assign ay = s1_gy[GRAD_WIDTH-1] ? $unsigned(-s1_gy) : $unsigned(s1_gy);
   // Window shift, fill tracking and the two pipeline stages.
   always_ff @(posedge clk) begin
      if (rst) begin
         c2 <= '0;
         c1_mid <= '0;
         fill <= '0;
         s1_gx <= '0;
         s1_gy <= '0;
         s1_valid <= 1'b0;
         out_gx <= '0;
         out_gy <= '0;
         out_mag <= '0;
         out_valid <= 1'b0;
      end else begin
         if (acc) begin
            c2 <= in_col;
            c1_mid <= c2[2*W-1:W];
            fill <= (fill == 2'd3) ? fill : fill + 2'd1;
            s1_gx <= gx;
            s1_gy <= gy;
         end
         if (s1_en) s1_valid <= acc && fill[1] && !in_border;
         if (s2_en) begin
            out_gx <= s1_gx;
            out_gy <= s1_gy;
            out_mag <= ax + ay;
            out_valid <= s1_valid;
         end
      end
   end
endmodule

// File: tb/tb_gradient_window.sv
// tb_gradient_window: directed stimulus with a window model feeding a result scoreboard
module tb_gradient_window;
   typedef struct {
      int gx;
      int gy;
      int mag;
   } res_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [23:0] in_col = '0;
   logic in_valid = 1'b0;
   logic in_border = 1'b0;
   logic out_ready = 1'b1;
   logic in_ready, out_valid;
   logic signed [8:0] out_gx, out_gy;
   logic [8:0] out_mag;
   int checks = 0;
   int errors = 0;
   int n_out = 0;
   int cyc = 0;
   int first_out = -1;
   int last_out = -1;
   res_t q[$];
   int w[3][3];
   int mfill = 0;
   bit stalled = 0;
   int hgx, hgy, hmag;

   gradient_window dut (
      .clk(clk), .rst(rst), .in_col(in_col), .in_valid(in_valid), .in_border(in_border),
      .in_ready(in_ready), .out_gx(out_gx), .out_gy(out_gy), .out_mag(out_mag),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL global_timeout observed running expected finished");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] col(input int r0, input int r1, input int r2);
      return {8'(r2), 8'(r1), 8'(r0)};
   endfunction

   function automatic int iabs(input int v);
      return v < 0 ? -v : v;
   endfunction

   // Reference model: full 3x3 window, gradients read from the post-shift window.
   task automatic model(input logic [23:0] c, input bit b);
      res_t r;
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 3; j++) w[i][j] = w[i+1][j];
      for (int j = 0; j < 3; j++) w[2][j] = int'(c[8*j +: 8]);
      r.gx = w[2][1] - w[0][1];
      r.gy = w[1][2] - w[1][0];
      r.mag = iabs(r.gx) + iabs(r.gy);
      if (mfill >= 2 && !b) q.push_back(r);
      if (mfill < 3) mfill++;
   endtask

   task automatic model_clear();
      q.delete();
      mfill = 0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) w[i][j] = 0;
   endtask

   task automatic try_beat(input logic [23:0] c, input bit b, output bit acc);
      in_col = c;
      in_border = b;
      in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      if (acc) model(c, b);
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [23:0] c, input bit b);
      bit acc;
      int n = 0;
      do begin
         try_beat(c, b, acc);
         n++;
      end while (!acc && n < 50);
      chk("send_accepted", int'(acc), 1);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      in_border = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      in_border = 1'b0;
      rst = 1'b1;
      model_clear();
      @(posedge clk);
      #1;
      rst = 1'b0;
      first_out = -1;
      last_out = -1;
   endtask

   task automatic basic_window(input string tag);
      int n0;
      n0 = n_out;
      send(col(10, 20, 30), 0);
      send(col(40, 50, 60), 0);
      send(col(70, 80, 90), 0);
      in_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_lat1_valid"}, int'(out_valid), 0);
      @(negedge clk);
      chk({tag, "_lat2_valid"}, int'(out_valid), 1);
      chk({tag, "_gx"}, int'(out_gx), 60);
      chk({tag, "_gy"}, int'(out_gy), 20);
      chk({tag, "_mag"}, int'(out_mag), 80);
      idle(3);
      chk({tag, "_count"}, n_out - n0, 1);
   endtask

   // Output monitor: scoreboard pop on each handshake, hold check while stalled.
   always @(negedge clk) begin
      cyc++;
      if (rst) stalled = 0;
      else begin
         if (stalled) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_gx", int'(out_gx), hgx);
            chk("hold_gy", int'(out_gy), hgy);
            chk("hold_mag", int'(out_mag), hmag);
         end
         if (out_valid && out_ready) begin
            n_out++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            if (q.size() == 0) begin
               checks++;
               errors++;
               $error("FAIL unexpected_out observed gx %0d gy %0d expected no output", out_gx, out_gy);
            end else begin
               res_t e;
               e = q.pop_front();
               chk("sb_gx", int'(out_gx), e.gx);
               chk("sb_gy", int'(out_gy), e.gy);
               chk("sb_mag", int'(out_mag), e.mag);
            end
         end
         stalled = out_valid && !out_ready;
         hgx = int'(out_gx);
         hgy = int'(out_gy);
         hmag = int'(out_mag);
      end
   end

   initial begin
      bit acc;
      int k, n0;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_gx", int'(out_gx), 0);
      chk("rst_gy", int'(out_gy), 0);
      chk("rst_mag", int'(out_mag), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_clear();

      basic_window("basic");

      do_reset();
      send(col(0, 255, 0), 0);
      send(col(255, 0, 0), 0);
      send(col(0, 0, 0), 0);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("neg_valid", int'(out_valid), 1);
      chk("neg_gx", int'(out_gx), -255);
      chk("neg_gy", int'(out_gy), -255);
      chk("neg_mag", int'(out_mag), 510);
      idle(3);

      do_reset();
      n0 = n_out;
      for (int i = 0; i < 10; i++) send(col(i, 2 * i, 3 * i), 0);
      idle(4);
      chk("stream_count", n_out - n0, 8);
      chk("stream_consecutive", last_out - first_out, 7);

      do_reset();
      n0 = n_out;
      k = 0;
      while (k < 4) begin
         send(col(k, 2 * k, 3 * k), 0);
         k++;
      end
      out_ready = 1'b0;
      for (int s = 1; s <= 5; s++) begin
         try_beat(col(k, 2 * k, 3 * k), 0, acc);
         if (acc) k++;
         if (s >= 3) chk("bp_in_ready_low", int'(acc), 0);
      end
      out_ready = 1'b1;
      while (k < 10) begin
         send(col(k, 2 * k, 3 * k), 0);
         k++;
      end
      idle(4);
      chk("bp_count", n_out - n0, 8);
      chk("bp_sb_drained", q.size(), 0);

      do_reset();
      n0 = n_out;
      for (int i = 0; i < 10; i++) send(col(i, 2 * i, 3 * i), (i == 4 || i == 5));
      idle(4);
      chk("border_count", n_out - n0, 6);

      do_reset();
      basic_window("prefill");
      out_ready = 1'b0;
      send(col(1, 2, 3), 0);
      idle(2);
      @(negedge clk);
      chk("rm_stalled_valid", int'(out_valid), 1);
      @(posedge clk);
      #1;
      do_reset();
      out_ready = 1'b1;
      @(negedge clk);
      chk("rm_out_valid", int'(out_valid), 0);
      chk("rm_in_ready", int'(in_ready), 1);
      @(posedge clk);
      #1;
      basic_window("after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
